// File: rtl/hrv_pkg.sv
// hrv_pkg: shared types and constants for the HRV engine scheduler
package hrv_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_OUT} state_t;
    localparam int DEF_WIN = 8;
    localparam int DEF_TMO = 63;
    localparam logic [7:0] ERR_CODE = 8'hFF;
endpackage

// File: rtl/hrv_rr_arbiter.sv
// hrv_rr_arbiter: round-robin one-hot arbiter whose priority rotates past the last grant
// Ports: clk/rst (sync, active-high); req request vector; adv commits the current grant;
//        gnt one-hot grant (combinational from req and the stored priority mask).
module hrv_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] mask, hi;

    // mask holds the channels strictly above the last grant; x & -x isolates the lowest set bit
    always_comb begin
        hi  = req & mask;
        gnt = (|hi) ? (hi & (~hi + ONE)) : (req & (~req + ONE));
    end

    // granting the top channel shifts out to zero, which wraps priority back to channel 0
    always_ff @(posedge clk)
        if (rst) mask <= '1;
        else if (adv) mask <= ~((gnt << 1) - ONE);
endmodule

// File: rtl/hrv_engine_sched.sv
// hrv_engine_sched: per-channel RR window buffering, round-robin scheduling onto one RMSSD engine
// Ports: clk/rst (sync, active-high); ch_valid/ch_rr/ch_ready per-channel sample input;
//        eng_clr/eng_valid/eng_rr out and eng_done/eng_result in for the engine;
//        res_valid/res_ready handshake carrying res_chan/res_rmssd/res_err.
module hrv_engine_sched
    import hrv_pkg::*;
#(
    parameter int NCH = 4,
    parameter int WIN = DEF_WIN,
    parameter int TMO = DEF_TMO
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [8*NCH-1:0]         ch_rr,
    output logic [NCH-1:0]           ch_ready,
    output logic                     eng_clr,
    output logic                     eng_valid,
    output logic [7:0]               eng_rr,
    input  logic                     eng_done,
    input  logic [7:0]               eng_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(NCH)-1:0]   res_chan,
    output logic [7:0]               res_rmssd,
    output logic                     res_err
);
    localparam int CHW = $clog2(NCH);
    localparam int PW  = $clog2(WIN);
    localparam int CW  = $clog2((TMO > WIN ? TMO : WIN) + 1);

    state_t         state, nstate;
    logic [7:0]     mem [NCH][WIN];
    logic [PW-1:0]  wptr [NCH];
    logic [NCH-1:0] full, req, gnt;
    logic [CHW-1:0] gsel, gidx;
    logic [CW-1:0]  cnt;
    logic           last_s, wait_end;

    assign ch_ready = ~full;
    assign last_s   = state == S_STREAM && cnt == CW'(WIN - 1);
    assign wait_end = state == S_WAIT && (eng_done || cnt == CW'(TMO));

    // the channel being serviced keeps its full flag but must not re-request
    always_comb begin
        req  = '0;
        gsel = '0;
        for (int i = 0; i < NCH; i++) begin
            req[i] = full[i] && !(state != S_IDLE && gidx == CHW'(i));
            if (gnt[i]) gsel = CHW'(i);
        end
    end

    hrv_rr_arbiter #(.N(NCH)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .adv (state == S_IDLE && |req),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
            for (int i = 0; i < NCH; i++) wptr[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    wptr[i] <= (wptr[i] == PW'(WIN - 1)) ? '0 : wptr[i] + PW'(1);
                    if (wptr[i] == PW'(WIN - 1)) full[i] <= 1'b1;
                end
                if (last_s && gidx == CHW'(i)) full[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NCH; i++)
            if (ch_valid[i] && ch_ready[i]) mem[i][wptr[i]] <= ch_rr[8*i +: 8];

    always_ff @(posedge clk)
        state <= rst ? S_IDLE : nstate;

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:   if (|req) nstate = S_CLEAR;
            S_CLEAR:  nstate = S_STREAM;
            S_STREAM: if (last_s) nstate = S_WAIT;
            S_WAIT:   if (wait_end) nstate = S_OUT;
            S_OUT:    if (res_ready) nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_comb begin
        eng_clr   = state == S_CLEAR;
        eng_valid = state == S_STREAM;
        eng_rr    = eng_valid ? mem[gidx][cnt[PW-1:0]] : 8'd0;
        res_valid = state == S_OUT;
    end

    // cnt restarts on every state change, so it indexes STREAM and times WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            gidx      <= '0;
            res_chan  <= '0;
            res_rmssd <= '0;
            res_err   <= 1'b0;
        end else begin
            cnt <= (state != nstate) ? '0 : cnt + CW'(1);
            if (state == S_IDLE && |req) gidx <= gsel;
            if (wait_end) begin
                res_chan  <= gidx;
                res_rmssd <= eng_done ? eng_result : ERR_CODE;
                res_err   <= !eng_done;
            end
        end
    end
endmodule

// File: tb/tb_hrv_engine_sched.sv
// tb_hrv_engine_sched: scoreboard bench for the HRV engine scheduler with a behavioural engine
module tb_hrv_engine_sched;
    localparam int NCH = 4;
    localparam int WIN = 8;
    localparam int TMO = 63;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] v;
        logic       e;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH-1:0]   ch_valid = '0;
    logic [8*NCH-1:0] ch_rr = '0;
    logic [NCH-1:0]   ch_ready;
    logic             eng_clr, eng_valid, res_valid, res_err;
    logic             eng_done = 1'b0;
    logic             res_ready = 1'b1;
    logic [7:0]       eng_rr, res_rmssd;
    logic [7:0]       eng_result = 8'd0;
    logic [1:0]       res_chan;

    logic [7:0] exp_s[$];
    res_t       exp_r[$];
    logic [7:0] e_s;
    res_t       e_r;
    int  checks = 0, failures = 0;
    int  cyc = 0, clr_cnt = 0, val_cnt = 0, t_clr = 0, t_res = 0, got = 0;
    bit  res_seen = 1'b0, eng_en = 1'b1, ok;
    logic [7:0] eng_ret = 8'd2;

    always #5 clk = ~clk;

    hrv_engine_sched #(.NCH(NCH), .WIN(WIN), .TMO(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_valid   (ch_valid),
        .ch_rr      (ch_rr),
        .ch_ready   (ch_ready),
        .eng_clr    (eng_clr),
        .eng_valid  (eng_valid),
        .eng_rr     (eng_rr),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_chan   (res_chan),
        .res_rmssd  (res_rmssd),
        .res_err    (res_err)
    );

    // engine model: raises done (level) once a full window has been streamed, if enabled
    always @(negedge clk) begin
        if (rst || eng_clr) begin
            got = 0;
            eng_done = 1'b0;
        end else begin
            if (eng_valid) got++;
            eng_done = eng_en && got >= WIN;
        end
        eng_result = eng_ret;
    end

    // scoreboard: streamed samples and handshaken results are checked against queued expectations
    always @(negedge clk) begin
        cyc++;
        if (eng_clr) begin
            clr_cnt++;
            t_clr = cyc;
            res_seen = 1'b0;
        end
        if (eng_valid) begin
            val_cnt++;
            checks++;
            if (exp_s.size() == 0) begin
                failures++;
                $display("FAIL stream_unexpected got=%0d expected=none", eng_rr);
            end else begin
                e_s = exp_s.pop_front();
                if (eng_rr !== e_s) begin
                    failures++;
                    $display("FAIL stream_data got=%0d expected=%0d", eng_rr, e_s);
                end
            end
        end else begin
            checks++;
            if (eng_rr !== 8'd0) begin
                failures++;
                $display("FAIL eng_rr_idle got=%0d expected=0", eng_rr);
            end
        end
        if (res_valid && !res_seen) begin
            res_seen = 1'b1;
            t_res = cyc;
        end
        if (res_valid && res_ready) begin
            checks++;
            if (exp_r.size() == 0) begin
                failures++;
                $display("FAIL result_unexpected got chan=%0d rmssd=%0d err=%0d expected=none",
                         res_chan, res_rmssd, res_err);
            end else begin
                e_r = exp_r.pop_front();
                if ({res_chan, res_rmssd, res_err} !== e_r) begin
                    failures++;
                    $display("FAIL result got chan=%0d rmssd=%0d err=%0d expected chan=%0d rmssd=%0d err=%0d",
                             res_chan, res_rmssd, res_err, e_r.ch, e_r.v, e_r.e);
                end
            end
        end
    end

    function automatic logic [7:0] dat(int c, int seed, int k);
        return (seed == 0) ? (((k % 2) == 1) ? 8'd12 : 8'd10) : 8'(seed + 16 * c + 3 * k);
    endfunction

    task automatic push_exp(int c, int seed, int n);
        for (int k = 0; k < n; k++) exp_s.push_back(dat(c, seed, k));
    endtask

    task automatic fill(logic [NCH-1:0] mask, int seed, int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if ((ch_ready & mask) !== mask) begin
                failures++;
                $display("FAIL fill_ready sample=%0d ready=%b expected ones at %b", k, ch_ready, mask);
            end
            ch_valid = mask;
            for (int c = 0; c < NCH; c++) ch_rr[8*c +: 8] = dat(c, seed, k);
        end
        @(negedge clk);
        ch_valid = '0;
        if (n == WIN) begin
            checks++;
            if ((ch_ready & mask) !== '0) begin
                failures++;
                $display("FAIL fill_full ready=%b expected zeros at %b", ch_ready, mask);
            end
        end
    endtask

    task automatic wait_empty(int max, output bit done);
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge clk);
            done = exp_s.size() == 0 && exp_r.size() == 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({eng_clr, eng_valid, res_valid, res_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got clr=%b valid=%b rv=%b err=%b expected 0", eng_clr, eng_valid, res_valid, res_err);
        end
        checks++;
        if (eng_rr !== 8'd0 || res_rmssd !== 8'd0) begin
            failures++;
            $display("FAIL reset_data got eng_rr=%0d rmssd=%0d expected 0", eng_rr, res_rmssd);
        end
        checks++;
        if (res_chan !== 2'd0) begin
            failures++;
            $display("FAIL reset_chan got=%0d expected=0", res_chan);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ch_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_ready got=%b expected=1111", ch_ready);
        end
        checks++;
        if (res_valid !== 1'b0 || eng_clr !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got rv=%b clr=%b expected 0", res_valid, eng_clr);
        end
    endtask

    task automatic test_single();
        eng_en = 1'b1;
        eng_ret = 8'd2;
        clr_cnt = 0;
        val_cnt = 0;
        push_exp(0, 0, WIN);
        exp_r.push_back({2'd0, 8'd2, 1'b0});
        fill(4'b0001, 0, WIN);
        wait_empty(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout pending=%0d/%0d expected 0/0", exp_s.size(), exp_r.size());
        end
        checks++;
        if (clr_cnt != 1) begin
            failures++;
            $display("FAIL single_clr_cycles got=%0d expected=1", clr_cnt);
        end
        checks++;
        if (val_cnt != WIN) begin
            failures++;
            $display("FAIL single_valid_cycles got=%0d expected=%0d", val_cnt, WIN);
        end
        checks++;
        if (t_res - t_clr != WIN + 2) begin
            failures++;
            $display("FAIL single_latency got=%0d expected=%0d", t_res - t_clr, WIN + 2);
        end
        @(negedge clk);
        checks++;
        if (ch_ready !== 4'hF) begin
            failures++;
            $display("FAIL single_ready_after got=%b expected=1111", ch_ready);
        end
    endtask

    task automatic arb_round(logic [NCH-1:0] mask, int seed, int first, int second);
        push_exp(first, seed, WIN);
        exp_r.push_back({2'(first), 8'd5, 1'b0});
        if (second >= 0) begin
            push_exp(second, seed, WIN);
            exp_r.push_back({2'(second), 8'd5, 1'b0});
        end
        fill(mask, seed, WIN);
        wait_empty(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL arb_timeout seed=%0d pending=%0d/%0d expected 0/0", seed, exp_s.size(), exp_r.size());
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        eng_ret = 8'd5;
        arb_round(4'b1010, 50, 1, 3);
        arb_round(4'b1010, 60, 1, 3);
        arb_round(4'b0010, 70, 1, -1);
        arb_round(4'b1010, 80, 3, 1);
    endtask

    task automatic test_timeout();
        eng_en = 1'b0;
        push_exp(2, 20, WIN);
        exp_r.push_back({2'd2, 8'hFF, 1'b1});
        fill(4'b0100, 20, WIN);
        wait_empty(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_no_result pending=%0d/%0d expected 0/0", exp_s.size(), exp_r.size());
        end
        checks++;
        if (t_res - t_clr - WIN - 1 < TMO || t_res - t_clr - WIN - 1 > TMO + 1) begin
            failures++;
            $display("FAIL timeout_wait_cycles got=%0d expected=%0d..%0d", t_res - t_clr - WIN - 1, TMO, TMO + 1);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_back_idle got rv=%b expected=0", res_valid);
        end
        eng_en = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [10:0] held;
        bit stable, quiet, rdy;
        res_ready = 1'b0;
        eng_ret = 8'd7;
        push_exp(0, 30, WIN);
        push_exp(1, 30, WIN);
        exp_r.push_back({2'd0, 8'd7, 1'b0});
        exp_r.push_back({2'd1, 8'd7, 1'b0});
        fill(4'b0001, 30, WIN);
        fill(4'b0010, 30, WIN);
        for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_result got rv=%b expected=1", res_valid);
        end
        held = {res_chan, res_rmssd, res_err};
        stable = 1'b1;
        quiet = 1'b1;
        rdy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= res_valid === 1'b1 && {res_chan, res_rmssd, res_err} === held;
            quiet &= eng_clr === 1'b0 && eng_valid === 1'b0;
            rdy &= ch_ready === 4'b1101;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_stable got rv=%b res=%h expected rv=1 res=%h", res_valid, {res_chan, res_rmssd, res_err}, held);
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL bp_engine_quiet got clr=%b valid=%b expected 0", eng_clr, eng_valid);
        end
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL bp_ready got=%b expected=1101", ch_ready);
        end
        res_ready = 1'b1;
        wait_empty(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_drain pending=%0d/%0d expected 0/0", exp_s.size(), exp_r.size());
        end
    endtask

    task automatic test_concurrent_fill();
        eng_ret = 8'd3;
        push_exp(0, 40, WIN);
        push_exp(2, 50, WIN);
        exp_r.push_back({2'd0, 8'd3, 1'b0});
        exp_r.push_back({2'd2, 8'd3, 1'b0});
        fill(4'b0001, 40, WIN);
        for (int i = 0; i < 20 && !eng_valid; i++) @(negedge clk);
        checks++;
        if (eng_valid !== 1'b1) begin
            failures++;
            $display("FAIL conc_no_stream got valid=%b expected=1", eng_valid);
        end
        fill(4'b0100, 50, WIN);
        wait_empty(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL conc_drain pending=%0d/%0d expected 0/0", exp_s.size(), exp_r.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        bit quiet;
        eng_ret = 8'd9;
        fill(4'b1000, 60, 3);
        push_exp(0, 90, 4);
        fill(4'b0001, 90, WIN);
        for (int i = 0; i < 20 && !eng_valid; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (eng_valid !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs got valid=%b rv=%b expected 0", eng_valid, res_valid);
        end
        checks++;
        if (ch_ready !== 4'hF) begin
            failures++;
            $display("FAIL rst_mid_ready got=%b expected=1111", ch_ready);
        end
        checks++;
        if (exp_s.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_streamed got pending=%0d expected=0", exp_s.size());
        end
        rst = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            quiet &= res_valid === 1'b0 && eng_clr === 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL rst_mid_quiet got rv=%b clr=%b expected 0", res_valid, eng_clr);
        end
        push_exp(3, 100, WIN);
        exp_r.push_back({2'd3, 8'd9, 1'b0});
        fill(4'b1000, 100, WIN);
        wait_empty(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rst_mid_refill pending=%0d/%0d expected 0/0", exp_s.size(), exp_r.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_timeout();
        test_backpressure();
        test_concurrent_fill();
        test_reset_mid_stream();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hrv_engine_sched.md
HRV_ENGINE_SCHED -- requirements
Module: hrv_engine_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of RR-interval channels sharing one RMSSD engine.
REQ-002 SHALL have parameter WIN, default 8, RR samples per RMSSD window.
REQ-003 SHALL have parameter TMO, default 63, max cycles waiting for engine done.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port ch_valid  in  NCH  per-channel RR sample valid.
REQ-007 SHALL have port ch_rr  in  8*NCH  per-channel RR sample; channel i at bits [8i+7:8i].
REQ-008 SHALL have port ch_ready  out  NCH  per-channel buffer can accept a sample.
REQ-009 SHALL have port eng_clr  out  1  one-cycle engine clear pulse.
REQ-010 SHALL have port eng_valid  out  1  engine sample strobe.
REQ-011 SHALL have port eng_rr  out  8  engine sample data.
REQ-012 SHALL have port eng_done  in  1  engine result ready, level.
REQ-013 SHALL have port eng_result  in  8  engine RMSSD value.
REQ-014 SHALL have port res_valid  out  1  result available.
REQ-015 SHALL have port res_ready  in  1  result consumer accepts.
REQ-016 SHALL have port res_chan  out  clog2(NCH)  channel of result.
REQ-017 SHALL have port res_rmssd  out  8  RMSSD value; 8'hFF on error.
REQ-018 SHALL have port res_err  out  1  engine timeout flag.

Function
REQ-019 SHALL hold one WIN-deep buffer, write pointer and full flag per channel; sample accepted when ch_valid[i] & ch_ready[i].
REQ-020 SHALL drive ch_ready[i] = !full[i]; full set when WIN-th sample written, cleared the cycle after that channel's last sample is streamed.
REQ-021 SHALL request engine for channel i while full[i] and not currently granted.
REQ-022 SHALL arbitrate round-robin among requests in IDLE only; priority starts at channel after last grant; after reset channel 0 highest.
REQ-023 SHALL sequence FSM IDLE -> CLEAR -> STREAM -> WAIT -> OUT -> IDLE.
REQ-024 IDLE: on any request, latch grant, go CLEAR next cycle; no request, stay.
REQ-025 CLEAR: eng_clr=1 exactly one cycle, then STREAM.
REQ-026 STREAM: eng_valid=1 for WIN consecutive cycles, eng_rr = granted buffer entries 0..WIN-1 in write order; then WAIT.
REQ-027 WAIT: cycle counter from 0; eng_done=1 -> capture eng_result, res_err=0, go OUT; counter reaches TMO without done -> res_rmssd=8'hFF, res_err=1, go OUT.
REQ-028 OUT: res_valid=1, res_chan/res_rmssd/res_err stable until res_valid & res_ready; then IDLE; no new grant while OUT.
REQ-029 eng_clr, eng_valid SHALL be 0 outside CLEAR/STREAM; eng_rr 0 outside STREAM.
REQ-030 SHALL ignore eng_done outside WAIT.
REQ-031 Granted channel's buffer SHALL not accept samples until freed (REQ-020); other channels fill concurrently.
REQ-032 Minimum grant-to-result latency SHALL be 1 (CLEAR) + WIN + 1 cycles from leaving IDLE to first done sample; throughput one window per arbitration cycle.

Reset
REQ-033 rst=1 at any clock edge SHALL force IDLE, clear all pointers/full flags, priority to channel 0, counter 0.
REQ-034 During/after reset outputs SHALL be: ch_ready all 1 (after release), eng_clr 0, eng_valid 0, eng_rr 0, res_valid 0, res_chan 0, res_rmssd 0, res_err 0.
REQ-035 Reset mid-STREAM/WAIT/OUT SHALL discard buffered samples and pending result; no eng_clr issued by reset.

Structure
REQ-036 SHALL place FSM state enum, default WIN, TMO and error code 8'hFF in shared package hrv_pkg.
REQ-037 SHALL implement arbiter as sub-module hrv_rr_arbiter (request vector, advance strobe, one-hot grant).

Verification
REQ-038 Single channel 0 pushes 10,12,10,12,10,12,10,12; engine model returns 2 -> eng_clr 1 cycle, 8 eng_valid cycles in order, res_chan=0, res_rmssd=2, res_err=0.
REQ-039 Channels 1 and 3 full same cycle after reset -> grant 1 then 3; next simultaneous 1&3 request -> 3 before 1 only if last grant was 1.
REQ-040 Engine never asserts done -> after TMO cycles in WAIT res_rmssd=8'hFF, res_err=1; FSM returns IDLE after handshake.
REQ-041 res_ready held 0 for 20 cycles in OUT -> outputs stable, no eng_clr, other full channels wait; ch_ready of non-full channels stays 1.
REQ-042 rst pulsed at 4th STREAM cycle -> eng_valid 0 next cycle, all ch_ready 1, res_valid 0, no result emitted.
REQ-043 Channel 2 pushes sample every cycle during channel 0 STREAM -> channel 2 fills independently, ch_ready[2] drops after 8th sample.
